m_unit_dispatch: RTL

//   Issue/writeback stage in front of the RV32M multiply/divide unit. Accepts one M-extension op from execute,

---
 rtl/m_unit_dispatch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/m_unit_dispatch.sv
// m_unit_dispatch: issue/writeback stage in front of the RV32M multiply/divide unit
// Ports: i_clk/i_rst (async active-high); issue side i_issue_valid/o_issue_ready/i_issue_m_cnt/
//   i_issue_rs1/i_issue_rs2/i_issue_rd; i_flush; RV32M side o_m_start/o_m_cnt/o_m_rs1/o_m_rs2/
//   o_m_stall/i_m_out/i_m_ready; writeback o_wb_valid/i_wb_ack/o_wb_rd/o_wb_data; o_busy.
// Optional: define MDU_RESULT_CACHE_EN to reuse the last completed result for an identical op.
module m_unit_dispatch #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_issue_valid,
  output logic            o_issue_ready,
  input  logic [2:0]      i_issue_m_cnt,
  input  logic [XLEN-1:0] i_issue_rs1,
  input  logic [XLEN-1:0] i_issue_rs2,
  input  logic [RD_W-1:0] i_issue_rd,
  input  logic            i_flush,
  output logic            o_m_start,
  output logic [2:0]      o_m_cnt,
  output logic [XLEN-1:0] o_m_rs1,
  output logic [XLEN-1:0] o_m_rs2,
  output logic            o_m_stall,
  input  logic [XLEN-1:0] i_m_out,
  input  logic            i_m_ready,
  output logic            o_wb_valid,
  input  logic            i_wb_ack,
  output logic [RD_W-1:0] o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_busy
);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SPEC, S_DRAIN} state_t;
  state_t r_state, w_next;
  logic [2:0] r_cnt;
  logic [XLEN-1:0] r_rs1, r_rs2, r_wb_data;
  logic [RD_W-1:0] r_rd, r_wb_rd;
  logic r_wb_valid;
  logic w_accept, w_special, w_hit, w_wb_load, w_zero;
  logic [XLEN-1:0] w_spec_data, w_wb_res;
  assign o_issue_ready = (r_state == S_IDLE) & ~r_wb_valid;
  assign w_accept = i_issue_valid & o_issue_ready & ~i_flush;
  // div-type by zero, or signed div/rem overflow, never reaches RV32M
  assign w_special = i_issue_m_cnt[2] & ((i_issue_rs2 == '0) |
    (~i_issue_m_cnt[0] & (i_issue_rs1 == MIN_NEG) & (i_issue_rs2 == '1)));
  assign w_zero = r_rs2 == '0;
`ifdef MDU_RESULT_CACHE_EN
  logic r_c_vld;
  logic [2:0] r_c_cnt;
  logic [XLEN-1:0] r_c_rs1, r_c_rs2, r_c_res;
  logic w_ovf;
  assign w_ovf = ~r_cnt[0] & (r_rs1 == MIN_NEG) & (r_rs2 == '1);
  assign w_hit = r_c_vld & (r_c_cnt == i_issue_m_cnt) & (r_c_rs1 == i_issue_rs1) & (r_c_rs2 == i_issue_rs2);
  // a SPEC op that is not a divide corner case can only be a cache hit
  assign w_spec_data = (r_cnt[2] & w_zero) ? (r_cnt[1] ? r_rs1 : '1) :
                       (r_cnt[2] & w_ovf) ? (r_cnt[1] ? '0 : MIN_NEG) : r_c_res;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_c_vld <= 1'b0;
      r_c_cnt <= '0;
      r_c_rs1 <= '0;
      r_c_rs2 <= '0;
      r_c_res <= '0;
    end else if (i_flush) begin
      r_c_vld <= 1'b0;
    end else if (r_state == S_RUN && i_m_ready) begin
      r_c_vld <= 1'b1;
      r_c_cnt <= r_cnt;
      r_c_rs1 <= r_rs1;
      r_c_rs2 <= r_rs2;
      r_c_res <= i_m_out;
    end
  end
`else
  assign w_hit = 1'b0;
  assign w_spec_data = w_zero ? (r_cnt[1] ? r_rs1 : '1) : (r_cnt[1] ? '0 : MIN_NEG);
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_accept ? ((w_special | w_hit) ? S_SPEC : S_RUN) : S_IDLE;
      // START stays up through a flush: RV32M only clears its operand latch on READY
      S_RUN:   w_next = i_m_ready ? S_IDLE : (i_flush ? S_DRAIN : S_RUN);
      S_SPEC:  w_next = S_IDLE;
      S_DRAIN: w_next = i_m_ready ? S_IDLE : S_DRAIN;
      default: w_next = S_IDLE;
    endcase
    w_wb_load = ~i_flush & ((r_state == S_SPEC) | ((r_state == S_RUN) & i_m_ready));
    w_wb_res = (r_state == S_SPEC) ? w_spec_data : i_m_out;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_rd <= '0;
      r_wb_valid <= 1'b0;
      r_wb_data <= '0;
      r_wb_rd <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt <= i_issue_m_cnt;
        r_rs1 <= i_issue_rs1;
        r_rs2 <= i_issue_rs2;
        r_rd <= i_issue_rd;
      end
      if (w_wb_load) begin
        r_wb_valid <= 1'b1;
        r_wb_data <= w_wb_res;
        r_wb_rd <= r_rd;
      end else if (i_wb_ack | i_flush) begin
        r_wb_valid <= 1'b0;
      end
    end
  end
  assign o_m_start = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign o_m_cnt = r_cnt;
  assign o_m_rs1 = r_rs1;
  assign o_m_rs2 = r_rs2;
  assign o_m_stall = 1'b0;
  assign o_wb_valid = r_wb_valid;
  assign o_wb_rd = r_wb_rd;
  assign o_wb_data = r_wb_data;
  assign o_busy = (r_state != S_IDLE) | r_wb_valid;
endmodule
